// File: rtl/pipe_pkg.sv
// Shared definitions for the OpenMIPS inter-stage pipeline registers:
// stall encoding, stage-state codes and the EX/MEM payload layout.
package pipe_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    localparam int EXMEM_W = 213;

    // Bit offsets (LSB) of each EX/MEM field inside the flat payload.
    localparam int OFS_CP0_DATA  = 0;
    localparam int OFS_CP0_WADDR = 32;
    localparam int OFS_CP0_WE    = 37;
    localparam int OFS_REG2      = 38;
    localparam int OFS_MEM_ADDR  = 70;
    localparam int OFS_ALUOP     = 102;
    localparam int OFS_WHILO     = 110;
    localparam int OFS_LO        = 111;
    localparam int OFS_HI        = 143;
    localparam int OFS_WDATA     = 175;
    localparam int OFS_WREG      = 207;
    localparam int OFS_WD        = 208;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
        logic        cp0_we;
        logic [4:0]  cp0_waddr;
        logic [31:0] cp0_data;
    } exmem_t;

    localparam logic [EXMEM_W-1:0] EXMEM_NOP = '0;

    function automatic logic [EXMEM_W-1:0] exmem_pack(input exmem_t f);
        return f;
    endfunction

    function automatic exmem_t exmem_unpack(input logic [EXMEM_W-1:0] v);
        return exmem_t'(v);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of stage-boundary signals between control, producer and consumer.
interface pipe_stage_reg_if #(
    parameter int DATA_W  = 213,
    parameter int CARRY_W = 66,
    parameter int STALL_W = 6,
    parameter int PERF_W  = 16
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_payload;
    logic [CARRY_W-1:0] carry_i;
    logic               out_valid;
    logic [DATA_W-1:0]  out_payload;
    logic [CARRY_W-1:0] carry_o;
    logic [1:0]         stage_state;
    logic [PERF_W-1:0]  bubble_cnt;
    logic [PERF_W-1:0]  hold_cnt;

    modport master (
        output stall, flush, in_valid, in_payload, carry_i,
        input  out_valid, out_payload, carry_o, stage_state, bubble_cnt, hold_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_payload, carry_i,
        output out_valid, out_payload, carry_o, stage_state, bubble_cnt, hold_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    // Count up on inc, stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with bubble/hold/flush control and a
// multi-cycle carry-state loop-back to the producing stage.
//
// state  | meaning
// RUN    | producer advances, payload and valid captured
// BUBBLE | producer stalled, consumer runs: insert NOP, loop carry back
// HOLD   | both stalled: keep payload, loop carry back
// FLUSH  | exception: kill contents and any multi-cycle state
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 213,
    parameter int CARRY_W = 66,
    parameter int STALL_W = 6,
    parameter int STAGE_IDX = 3,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
    parameter int PERF_W  = 16
) (
    input logic clk,
    input logic rst,
    pipe_stage_reg_if.slave bus
);
    generate
        if (STAGE_IDX < 0 || STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX out of range 0..STALL_W-2");
        end
        if (CARRY_W < 1) begin : g_bad_carry_w
            $error("pipe_stage_reg: CARRY_W must be at least 1");
        end
    endgenerate

    logic s;
    logic n;
    logic bubble_inc;
    logic hold_inc;
    logic unused_stall;

    assign s = (bus.stall[STAGE_IDX] == STOP);
    assign n = (bus.stall[STAGE_IDX+1] == STOP);
    // Only the two bits around this boundary matter.
    assign unused_stall = ^bus.stall;

    assign bubble_inc = !bus.flush && s && !n;
    assign hold_inc   = !bus.flush && s && n;

    // Priority: flush, bubble, run, hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_payload <= NOP_PAYLOAD;
            bus.carry_o     <= '0;
            bus.stage_state <= ST_RUN;
        end else if (bus.flush) begin
            bus.out_valid   <= 1'b0;
            bus.out_payload <= NOP_PAYLOAD;
            bus.carry_o     <= '0;
            bus.stage_state <= ST_FLUSH;
        end else if (s && !n) begin
            bus.out_valid   <= 1'b0;
            bus.out_payload <= NOP_PAYLOAD;
            bus.carry_o     <= bus.carry_i;
            bus.stage_state <= ST_BUBBLE;
        end else if (!s) begin
            bus.out_valid   <= bus.in_valid;
            bus.out_payload <= bus.in_payload;
            bus.carry_o     <= '0;
            bus.stage_state <= ST_RUN;
        end else begin
            bus.carry_o     <= bus.carry_i;
            bus.stage_state <= ST_HOLD;
        end
    end

    sat_counter #(.W(PERF_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bus.bubble_cnt)
    );

    sat_counter #(.W(PERF_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hold_inc),
        .count (bus.hold_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (EX/MEM defaults, PERF_W=4).
module tb_pipe_stage_reg;
    localparam int DATA_W  = 213;
    localparam int CARRY_W = 66;
    localparam int STALL_W = 6;
    localparam int PERF_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0]  pat_a5;
    logic [DATA_W-1:0]  pat_5a;
    logic [CARRY_W-1:0] madd_carry;
    logic [CARRY_W-1:0] hold_carry;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CARRY_W(CARRY_W), .STALL_W(STALL_W), .PERF_W(PERF_W)) bus ();

    pipe_stage_reg #(
        .DATA_W(DATA_W), .CARRY_W(CARRY_W), .STALL_W(STALL_W),
        .STAGE_IDX(3), .NOP_PAYLOAD('0), .PERF_W(PERF_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [DATA_W-1:0] p,
                           input logic [CARRY_W-1:0] c, input logic [1:0] st,
                           input int bc, input int hc);
        chk({tag, ".valid"}, 256'(bus.out_valid), 256'(v));
        chk({tag, ".payload"}, 256'(bus.out_payload), 256'(p));
        chk({tag, ".carry"}, 256'(bus.carry_o), 256'(c));
        chk({tag, ".state"}, 256'(bus.stage_state), 256'(st));
        chk({tag, ".bubble_cnt"}, 256'(bus.bubble_cnt), 256'(bc));
        chk({tag, ".hold_cnt"}, 256'(bus.hold_cnt), 256'(hc));
    endtask

    initial begin
        pat_a5     = {27{8'hA5}};
        pat_5a     = {27{8'h5A}};
        madd_carry = {64'h0000_0001_0000_0002, 2'd1};
        hold_carry = {64'h1234_5678_9ABC_DEF0, 2'd2};

        bus.stall      = '0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_payload = '0;
        bus.carry_i    = '0;

        // Reset state
        #1 rst = 1'b1;
        step();
        chk_all("reset", 1'b0, '0, '0, 2'd0, 0, 0);
        rst = 1'b0;

        // RUN: capture A5 pattern, carry_i ignored
        bus.in_valid   = 1'b1;
        bus.in_payload = pat_a5;
        bus.carry_i    = madd_carry;
        step();
        chk_all("run_a5", 1'b1, pat_a5, '0, 2'd0, 0, 0);

        // RUN with in_valid=0 still captures payload
        bus.in_valid   = 1'b0;
        bus.in_payload = 213'h33;
        step();
        chk_all("run_invalid", 1'b0, 213'h33, '0, 2'd0, 0, 0);

        // BUBBLE x2 for multi-cycle madd
        bus.in_valid   = 1'b1;
        bus.in_payload = pat_a5;
        bus.stall      = 6'b001111;
        step();
        chk_all("bubble1", 1'b0, '0, madd_carry, 2'd1, 1, 0);
        step();
        chk_all("bubble2", 1'b0, '0, madd_carry, 2'd1, 2, 0);

        // Load 5A then HOLD x3
        bus.stall      = 6'b000000;
        bus.in_payload = pat_5a;
        step();
        chk_all("load_5a", 1'b1, pat_5a, '0, 2'd0, 2, 0);
        bus.stall      = 6'b011111;
        bus.in_payload = pat_a5;
        bus.in_valid   = 1'b0;
        bus.carry_i    = hold_carry;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_all("hold", 1'b1, pat_5a, hold_carry, 2'd2, 2, i);
        end

        // FLUSH beats bubble and hold
        bus.flush   = 1'b1;
        bus.stall   = 6'b001111;
        bus.carry_i = madd_carry;
        step();
        chk_all("flush_bubble", 1'b0, '0, '0, 2'd3, 2, 3);
        bus.stall = 6'b011111;
        step();
        chk_all("flush_hold", 1'b0, '0, '0, 2'd3, 2, 3);
        bus.flush = 1'b0;

        // Load 0x1234, then async reset mid-cycle
        bus.stall      = 6'b000000;
        bus.in_valid   = 1'b1;
        bus.in_payload = 213'h1234;
        step();
        chk_all("load_1234", 1'b1, 213'h1234, '0, 2'd0, 2, 3);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, '0, '0, 2'd0, 0, 0);
        rst = 1'b0;
        bus.in_payload = pat_5a;
        step();
        chk_all("post_rst_run", 1'b1, pat_5a, '0, 2'd0, 0, 0);

        // Saturation: 20 bubbles, counter tops out at 15
        bus.stall   = 6'b001111;
        bus.carry_i = madd_carry;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("sat_bubble_cnt", 256'(bus.bubble_cnt), 256'((i > 15) ? 15 : i));
        end
        chk("sat_state", 256'(bus.stage_state), 256'(2'd1));
        chk("sat_hold_cnt", 256'(bus.hold_cnt), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
